// File: rtl/wb_coef_loader_if.sv
// Stream-in / Wishbone-out bundle for the coefficient loader.
// The master modport is the loader side; the slave modport is the host stream plus the register bank.
interface wb_coef_loader_if #(
  parameter int CFGAW = 32,
  parameter int CFGDW = 32
) ();
  logic [CFGDW-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic             ack_i;
  logic             stall_i;
  logic [CFGAW-1:0] addr_o;
  logic [CFGDW-1:0] data_o;
  logic [CFGDW-1:0] data_i;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, ack_i, stall_i, data_i,
    output s_axis_tready, cyc_o, stb_o, we_o, addr_o, data_o
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, ack_i, stall_i, data_i,
    input  s_axis_tready, cyc_o, stb_o, we_o, addr_o, data_o
  );
endinterface

// File: rtl/wb_coef_loader.sv
// Streams a coefficient burst into a Wishbone register bank at consecutive addresses.
// An optional readback pass compares each register against a sign-extended shadow copy.
module wb_coef_loader #(
  parameter int CFGAW     = 32,
  parameter int CFGDW     = 32,
  parameter int COEFW     = 18,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64,
  parameter int VERIFY    = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  wb_coef_loader_if.master                 bus,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [2:0]                       err_o,
  output logic [$clog2(MAX_WORDS+1)-1:0]   words_o
);
  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int IW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WR    = 3'd2,
    ST_WACK  = 3'd3,
    ST_RD    = 3'd4,
    ST_RACK  = 3'd5,
    ST_DRAIN = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam state_t ST_AFTER_WR = (VERIFY != 0) ? ST_RD : ST_DONE;

  function automatic logic [CFGDW-1:0] sext_coef(input logic [COEFW-1:0] v);
    sext_coef = CFGDW'($signed(v));
  endfunction

  state_t           state_r, state_s;
  logic [WCW-1:0]   idx_r, idx_s, idx_inc_s, words_r, words_s;
  logic [CFGDW-1:0] word_r, word_s;
  logic             last_r, last_s;
  logic [TMW-1:0]   tmo_r, tmo_s;
  logic [2:0]       err_r, err_s;
  logic             accept_s, tmo_hit_s, mismatch_s;
  logic [COEFW-1:0] shadow_r [MAX_WORDS];

  logic             cyc_r, stb_r, we_r, tready_r, busy_r, done_r;
  logic             cyc_s, stb_s, we_s, tready_s, busy_s, done_s;
  logic [CFGAW-1:0] addr_r, addr_s;
  logic [CFGDW-1:0] data_r, data_s;

  assign accept_s   = tready_r & bus.s_axis_tvalid;
  assign idx_inc_s  = idx_r + WCW'(1);
  assign tmo_hit_s  = (tmo_r == TMW'(TIMEOUT - 1));
  assign mismatch_s = (bus.data_i != sext_coef(shadow_r[idx_r[IW-1:0]]));

  // Next-state and datapath update for the write, drain and readback phases
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    words_s = words_r;
    word_s  = word_r;
    last_s  = last_r;
    tmo_s   = tmo_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE, ST_FETCH: begin
        if (accept_s) begin
          word_s  = bus.s_axis_tdata;
          last_s  = bus.s_axis_tlast;
          state_s = ST_WR;
          if (state_r == ST_IDLE) begin
            err_s   = 3'b000;
            words_s = '0;
            idx_s   = '0;
          end else begin
            err_s   = err_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_WR: begin
        if (!bus.stall_i) begin
          tmo_s   = '0;
          state_s = ST_WACK;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_WACK: begin
        if (bus.ack_i) begin
          idx_s   = idx_inc_s;
          words_s = words_r + WCW'(1);
          if (last_r) begin
            idx_s   = '0;
            state_s = ST_AFTER_WR;
          end else if (idx_inc_s == WCW'(MAX_WORDS)) begin
            // Bank is full but the stream is not finished: flag and swallow the rest
            idx_s    = '0;
            err_s[2] = 1'b1;
            state_s  = ST_DRAIN;
          end else begin
            state_s = ST_FETCH;
          end
        end else if (tmo_hit_s) begin
          err_s[0] = 1'b1;
          state_s  = last_r ? ST_DONE : ST_DRAIN;
        end else begin
          tmo_s = tmo_r + TMW'(1);
        end
      end
      ST_RD: begin
        if (!bus.stall_i) begin
          tmo_s   = '0;
          state_s = ST_RACK;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_RACK: begin
        if (bus.ack_i) begin
          err_s[1] = err_r[1] | mismatch_s;
          idx_s    = idx_inc_s;
          state_s  = (idx_inc_s == words_r) ? ST_DONE : ST_RD;
        end else if (tmo_hit_s) begin
          err_s[0] = 1'b1;
          state_s  = ST_DONE;
        end else begin
          tmo_s = tmo_r + TMW'(1);
        end
      end
      ST_DRAIN: begin
        if (accept_s && bus.s_axis_tlast) begin
          state_s = err_r[0] ? ST_DONE : ST_AFTER_WR;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every port comes straight from a flop
  always_comb begin
    cyc_s    = 1'b0;
    stb_s    = 1'b0;
    we_s     = 1'b0;
    tready_s = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_s)
      ST_IDLE:  tready_s = 1'b1;
      ST_FETCH: begin cyc_s = 1'b1; tready_s = 1'b1; busy_s = 1'b1; end
      ST_WR:    begin cyc_s = 1'b1; stb_s = 1'b1; we_s = 1'b1; busy_s = 1'b1; end
      ST_WACK:  begin cyc_s = 1'b1; we_s = 1'b1; busy_s = 1'b1; end
      ST_RD:    begin cyc_s = 1'b1; stb_s = 1'b1; busy_s = 1'b1; end
      ST_RACK:  begin cyc_s = 1'b1; busy_s = 1'b1; end
      ST_DRAIN: begin cyc_s = ~err_s[0]; tready_s = 1'b1; busy_s = 1'b1; end
      ST_DONE:  done_s = 1'b1;
      default:  done_s = 1'b0;
    endcase
    addr_s = cyc_s ? (CFGAW'(BASE_ADDR) + CFGAW'(idx_s)) : '0;
    data_s = we_s ? word_s : '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      words_r  <= '0;
      word_r   <= '0;
      last_r   <= 1'b0;
      tmo_r    <= '0;
      err_r    <= 3'b000;
      cyc_r    <= 1'b0;
      stb_r    <= 1'b0;
      we_r     <= 1'b0;
      tready_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      words_r  <= words_s;
      word_r   <= word_s;
      last_r   <= last_s;
      tmo_r    <= tmo_s;
      err_r    <= err_s;
      cyc_r    <= cyc_s;
      stb_r    <= stb_s;
      we_r     <= we_s;
      tready_r <= tready_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      addr_r   <= addr_s;
      data_r   <= data_s;
    end
  end

  // Shadow copy of the low COEFW bits actually held by the target register
  always_ff @(posedge clk) begin
    if (state_r == ST_WR) begin
      shadow_r[idx_r[IW-1:0]] <= word_r[COEFW-1:0];
    end
  end

  assign bus.s_axis_tready = tready_r;
  assign bus.cyc_o         = cyc_r;
  assign bus.stb_o         = stb_r;
  assign bus.we_o          = we_r;
  assign bus.addr_o        = addr_r;
  assign bus.data_o        = data_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign err_o             = err_r;
  assign words_o           = words_r;
endmodule

// File: tb/tb_wb_coef_loader.sv
// Directed bench for wb_coef_loader: a stream driver, a Wishbone register-bank responder
// and queues of expected bus transactions checked as the loader issues them.
module tb_wb_coef_loader;
  localparam int MAXW = 6;
  localparam int BASE = 0;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       done;
  logic [2:0] err;
  logic [2:0] words;

  wb_coef_loader_if #(.CFGAW(32), .CFGDW(32)) bus ();

  wb_coef_loader #(
    .CFGAW(32), .CFGDW(32), .COEFW(18), .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW), .VERIFY(1), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy), .done_o(done), .err_o(err), .words_o(words)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_cnt = 0;
  int done_base = 0;
  int fall_cyc = 0;
  logic cyc_prev = 1'b0;

  logic [63:0] wr_q [$];
  logic [31:0] rd_q [$];
  logic [31:0] bdata [16];
  logic [31:0] mem [16];

  // responder configuration
  int          stall_left = 0;
  logic [31:0] stall_addr = 32'd0;
  logic        stall_seen = 1'b0;
  logic [63:0] snap = 64'd0;
  logic        hang_en = 1'b0;
  logic [31:0] hang_addr = 32'd0;
  logic        hang_seen = 1'b0;
  int          hang_cyc = 0;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'd0;
  logic [31:0] corrupt_val = 32'd0;
  logic        pending = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    cyc_prev <= bus.cyc_o;
    if (cyc_prev && !bus.cyc_o) fall_cyc <= cycle;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext18(input logic [31:0] d);
    logic [17:0] v;
    v = d[17:0];
    return {{14{v[17]}}, v};
  endfunction

  // Register bank model: stores what an 18-bit sign-extending target would hold
  initial begin
    logic [63:0] exp_wr;
    bus.ack_i   = 1'b0;
    bus.stall_i = 1'b0;
    bus.data_i  = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.ack_i   = 1'b0;
        bus.stall_i = 1'b0;
        pending     = 1'b0;
      end else begin
        bus.ack_i = 1'b0;
        if (pending) begin
          bus.ack_i = 1'b1;
          pending   = 1'b0;
        end
        if (bus.cyc_o && bus.stb_o) begin
          if (bus.we_o && stall_left > 0 && bus.addr_o == stall_addr) begin
            if (stall_seen) check("stall_hold", {bus.addr_o, bus.data_o}, snap);
            else snap = {bus.addr_o, bus.data_o};
            stall_seen  = 1'b1;
            stall_left  = stall_left - 1;
            bus.stall_i = 1'b1;
            bus.ack_i   = 1'b1;   // stray ack while the strobe is pending
          end else begin
            bus.stall_i = 1'b0;
            if (bus.we_o) begin
              if (wr_q.size() == 0) begin
                check("wr_unexpected", {bus.addr_o, bus.data_o}, 64'd0 - 64'd1);
              end else begin
                exp_wr = wr_q.pop_front();
                check("wr_txn", {bus.addr_o, bus.data_o}, exp_wr);
              end
              mem[bus.addr_o[3:0]] = sext18(bus.data_o);
              if (hang_en && bus.addr_o == hang_addr) begin
                hang_seen = 1'b1;
                hang_cyc  = cycle + 1;
              end else begin
                pending = 1'b1;
              end
            end else begin
              if (rd_q.size() == 0) check("rd_unexpected", 64'(bus.addr_o), 64'd0 - 64'd1);
              else check("rd_addr", 64'(bus.addr_o), 64'(rd_q.pop_front()));
              if (corrupt_en && bus.addr_o == corrupt_addr) bus.data_i = corrupt_val;
              else bus.data_i = mem[bus.addr_o[3:0]];
              pending = 1'b1;
            end
          end
        end else begin
          bus.stall_i = 1'b0;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = last;
    while (!bus.s_axis_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("tready_wait", 64'(n < 1000), 64'd1);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic run_burst(input int n, input int n_wr, input int n_rd);
    for (int i = 0; i < n_wr; i++) wr_q.push_back({32'(BASE + i), bdata[i]});
    for (int i = 0; i < n_rd; i++) rd_q.push_back(32'(BASE + i));
    done_base = done_cnt;
    for (int i = 0; i < n; i++) send_word(bdata[i], i == n - 1);
  endtask

  task automatic finish_burst(input string tag, input int exp_words, input logic [2:0] exp_err);
    int n;
    n = 0;
    while (done_cnt == done_base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(n < 2000), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    check({tag, "_words"}, 64'(words), 64'(exp_words));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_q_left"}, 64'(wr_q.size() + rd_q.size()), 64'd0);
    check({tag, "_idle"}, 64'({busy, bus.cyc_o, bus.stb_o}), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.s_axis_tdata  = 32'd0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({bus.cyc_o, bus.stb_o, bus.we_o, bus.s_axis_tready, busy, done, err, words}), 64'd0);
    check("reset_bus", {bus.addr_o, bus.data_o}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tready", 64'(bus.s_axis_tready), 64'd1);

    // 1: six words, tlast on the sixth (exactly fills the bank)
    for (int i = 0; i < 6; i++) bdata[i] = 32'(i + 1);
    run_burst(6, 6, 6);
    finish_burst("basic", 6, 3'b000);

    // 2: responder stalls four cycles on the second word
    stall_addr = 32'(BASE + 1);
    stall_left = 4;
    stall_seen = 1'b0;
    for (int i = 0; i < 6; i++) bdata[i] = 32'h0000_0A00 + 32'(i);
    run_burst(6, 6, 6);
    finish_burst("stall", 6, 3'b000);
    check("stall_consumed", 64'(stall_left), 64'd0);

    // 3: corrupted readback flags mismatch; a negative coefficient reads back clean
    bdata[0] = 32'h0003_0000;
    bdata[1] = 32'hFFFE_0000;
    corrupt_en   = 1'b1;
    corrupt_addr = 32'(BASE);
    corrupt_val  = 32'h0001_0000;
    run_burst(2, 2, 2);
    finish_burst("mismatch", 2, 3'b010);
    corrupt_en = 1'b0;
    bdata[0] = 32'hFFFE_0000;
    run_burst(1, 1, 1);
    finish_burst("neg_single", 1, 3'b000);

    // 4: third write never acknowledged
    hang_en   = 1'b1;
    hang_addr = 32'(BASE + 2);
    hang_seen = 1'b0;
    for (int i = 0; i < 6; i++) bdata[i] = 32'h0000_0100 + 32'(i);
    run_burst(6, 3, 0);
    finish_burst("timeout", 2, 3'b001);
    check("timeout_hit", 64'(hang_seen), 64'd1);
    check("timeout_latency", 64'(fall_cyc - hang_cyc), 64'd255);
    hang_en = 1'b0;

    // 5: nine words into a six-word bank
    for (int i = 0; i < 9; i++) bdata[i] = 32'h0000_0200 + 32'(i);
    run_burst(9, MAXW, MAXW);
    finish_burst("overflow", MAXW, 3'b100);

    // 6: reset while waiting for a write acknowledge
    hang_en   = 1'b1;
    hang_addr = 32'(BASE);
    hang_seen = 1'b0;
    wr_q.push_back({32'(BASE), 32'h0000_0777});
    send_word(32'h0000_0777, 1'b0);
    repeat (3) @(negedge clk);
    check("wack_before_rst", 64'({hang_seen, bus.cyc_o, bus.stb_o, bus.we_o}), 64'b1101);
    #2 rst = 1'b0;
    #1 check("rst_release_bus", 64'({bus.cyc_o, bus.stb_o, busy, bus.s_axis_tready}), 64'd0);
    hang_en = 1'b0;
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) bdata[i] = 32'h0000_0300 + 32'(i);
    run_burst(3, 3, 3);
    finish_burst("after_rst", 3, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
